// File: rtl/game_flow_fsm.sv
// Top-level game sequencer: title/play/dying/gameover/win flow, revive pulse,
// frame-clock synchronisation and a saturating BCD elapsed-time counter.
module game_flow_fsm #(
  parameter int unsigned FRAMES_PER_SEC    = 60,
  parameter int unsigned DEATH_HOLD_FRAMES = 90
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic        confirm,
  input  logic        gameover,
  input  logic        gamewin,
  output logic        revive,
  output logic        play_enable,
  output logic [2:0]  game_state,
  output logic [11:0] time_bcd,
  output logic        frame_tick
);

  localparam int unsigned FCW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam int unsigned HCW = 10;
  localparam int unsigned TW  = 12;
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAMES_PER_SEC - 1);
  localparam logic [HCW-1:0] HOLD_INIT  = HCW'(DEATH_HOLD_FRAMES);
  localparam logic [TW-1:0]  TIME_MAX   = 12'h999;

  typedef enum logic [2:0] {
    S_TITLE    = 3'd0,
    S_PLAYING  = 3'd1,
    S_DYING    = 3'd2,
    S_GAMEOVER = 3'd3,
    S_WIN      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       fsync_q;
  logic             frame_rise_c;
  logic             confirm_prev_q;
  logic             confirm_rise_c;
  logic [FCW-1:0]   frame_q, frame_d;
  logic [HCW-1:0]   hold_q, hold_d;
  logic [TW-1:0]    time_d;
  logic             revive_d;

  // Saturating three-digit BCD increment.
  function automatic logic [TW-1:0] bcd_inc(input logic [TW-1:0] t);
    logic [3:0] d0, d1, d2;
    {d2, d1, d0} = t;
    if (t != TIME_MAX) begin
      if (d0 == 4'd9) begin
        d0 = 4'd0;
        if (d1 == 4'd9) begin
          d1 = 4'd0;
          d2 = d2 + 4'd1;
        end else begin
          d1 = d1 + 4'd1;
        end
      end else begin
        d0 = d0 + 4'd1;
      end
    end
    return {d2, d1, d0};
  endfunction

  // frame_clk crosses in through two flops; the third flop gives the edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fsync_q    <= 3'b000;
      frame_tick <= 1'b0;
    end else begin
      fsync_q    <= {fsync_q[1:0], frame_clk};
      frame_tick <= frame_rise_c;
    end
  end

  assign frame_rise_c = fsync_q[1] & ~fsync_q[2];

  // confirm_prev resets high so a key held through reset is not a press.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) confirm_prev_q <= 1'b1;
    else          confirm_prev_q <= confirm;
  end

  assign confirm_rise_c = confirm & ~confirm_prev_q;

  // State, counters and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_TITLE;
      frame_q     <= '0;
      hold_q      <= '0;
      time_bcd    <= '0;
      revive      <= 1'b0;
      play_enable <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      hold_q      <= hold_d;
      time_bcd    <= time_d;
      revive      <= revive_d;
      play_enable <= (state_d == S_PLAYING);
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    hold_d   = hold_q;
    time_d   = time_bcd;
    revive_d = 1'b0;
    unique case (state_q)
      S_TITLE, S_GAMEOVER: begin
        if (confirm_rise_c) begin
          state_d  = S_PLAYING;
          revive_d = 1'b1;
          frame_d  = '0;
          time_d   = '0;
        end
      end
      S_PLAYING: begin
        // A tick landing in the revive cycle is dropped so the clear wins.
        if (frame_tick && !revive) begin
          if (frame_q == FRAME_LAST) begin
            frame_d = '0;
            time_d  = bcd_inc(time_bcd);
          end else begin
            frame_d = frame_q + FCW'(1);
          end
        end
        if (gameover) begin
          state_d = S_DYING;
          hold_d  = HOLD_INIT;
        end else if (gamewin) begin
          state_d = S_WIN;
        end
      end
      S_DYING: begin
        if (frame_tick) begin
          hold_d = hold_q - HCW'(1);
          if (hold_q == HCW'(1)) state_d = S_GAMEOVER;
        end
      end
      S_WIN: begin
        if (confirm_rise_c) state_d = S_TITLE;
      end
      default: state_d = S_TITLE;
    endcase
  end

  assign game_state = state_q;

endmodule

// File: tb/tb_game_flow_fsm.sv
// Directed self-checking bench for game_flow_fsm: a 60 fps instance for the
// game flow and a 1 fps instance for BCD ripple and saturation.
module tb_game_flow_fsm;

  logic        Clk;
  logic        Reset_n;
  logic        frame_clk, frame_clk_f;
  logic        confirm, gameover, gamewin;
  logic        revive, play_enable, frame_tick;
  logic [2:0]  game_state;
  logic [11:0] time_bcd;
  logic        revive_f, play_enable_f, frame_tick_f;
  logic [2:0]  game_state_f;
  logic [11:0] time_bcd_f;

  int vectors;
  int miscompares;
  int revive_cnt, revive_cnt_f, tick_cnt;

  game_flow_fsm #(.FRAMES_PER_SEC(60), .DEATH_HOLD_FRAMES(90)) u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .confirm(confirm),
    .gameover(gameover), .gamewin(gamewin), .revive(revive),
    .play_enable(play_enable), .game_state(game_state), .time_bcd(time_bcd),
    .frame_tick(frame_tick)
  );

  game_flow_fsm #(.FRAMES_PER_SEC(1), .DEATH_HOLD_FRAMES(90)) u_fast (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk_f), .confirm(confirm),
    .gameover(gameover), .gamewin(gamewin), .revive(revive_f),
    .play_enable(play_enable_f), .game_state(game_state_f), .time_bcd(time_bcd_f),
    .frame_tick(frame_tick_f)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  always @(negedge Clk) begin
    if (revive)     revive_cnt++;
    if (revive_f)   revive_cnt_f++;
    if (frame_tick) tick_cnt++;
  end

  task automatic frame_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk) frame_clk = 1'b1;
      @(negedge Clk) frame_clk = 1'b0;
    end
  endtask

  task automatic fast_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk) frame_clk_f = 1'b1;
      @(negedge Clk) frame_clk_f = 1'b0;
    end
  endtask

  task automatic settle();
    repeat (6) @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; confirm = 1'b1; gameover = 1'b0; gamewin = 1'b0;
    frame_clk = 1'b0; frame_clk_f = 1'b0;
    #3;
    vectors++; if (game_state !== 3'd0) begin miscompares++; $display("FAIL reset_state got %0d want 0", game_state); end
    vectors++; if (revive !== 1'b0) begin miscompares++; $display("FAIL reset_revive got %b want 0", revive); end
    vectors++; if (play_enable !== 1'b0) begin miscompares++; $display("FAIL reset_play_enable got %b want 0", play_enable); end
    vectors++; if (time_bcd !== 12'h000) begin miscompares++; $display("FAIL reset_time got %h want 000", time_bcd); end
    vectors++; if (frame_tick !== 1'b0) begin miscompares++; $display("FAIL reset_frame_tick got %b want 0", frame_tick); end
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      vectors++; if (game_state !== 3'd0 || revive !== 1'b0) begin miscompares++; $display("FAIL held_confirm got state %0d revive %b want 0 0", game_state, revive); end
    end
    confirm = 1'b0;
    @(negedge Clk) confirm = 1'b1;
    @(negedge Clk);
    vectors++; if (game_state !== 3'd1) begin miscompares++; $display("FAIL start_state got %0d want 1", game_state); end
    vectors++; if (revive !== 1'b1) begin miscompares++; $display("FAIL start_revive got %b want 1", revive); end
    vectors++; if (play_enable !== 1'b1) begin miscompares++; $display("FAIL start_play_enable got %b want 1", play_enable); end
    vectors++; if (game_state_f !== 3'd1 || revive_f !== 1'b1) begin miscompares++; $display("FAIL fast_start got state %0d revive %b want 1 1", game_state_f, revive_f); end
    @(negedge Clk);
    vectors++; if (revive !== 1'b0 || game_state !== 3'd1) begin miscompares++; $display("FAIL revive_width got revive %b state %0d want 0 1", revive, game_state); end
    confirm = 1'b0;
  endtask

  task automatic test_timer();
    int t0;
    t0 = tick_cnt;
    frame_pulses(125);
    settle();
    vectors++; if (tick_cnt - t0 !== 125) begin miscompares++; $display("FAIL tick_count got %0d want 125", tick_cnt - t0); end
    vectors++; if (time_bcd !== 12'h002) begin miscompares++; $display("FAIL time_125 got %h want 002", time_bcd); end
    vectors++; if (game_state !== 3'd1) begin miscompares++; $display("FAIL timer_state got %0d want 1", game_state); end
  endtask

  task automatic test_saturate();
    fast_pulses(10);
    settle();
    vectors++; if (time_bcd_f !== 12'h010) begin miscompares++; $display("FAIL ripple_tens got %h want 010", time_bcd_f); end
    fast_pulses(90);
    settle();
    vectors++; if (time_bcd_f !== 12'h100) begin miscompares++; $display("FAIL ripple_hundreds got %h want 100", time_bcd_f); end
    fast_pulses(899);
    settle();
    vectors++; if (time_bcd_f !== 12'h999) begin miscompares++; $display("FAIL reach_999 got %h want 999", time_bcd_f); end
    fast_pulses(6);
    settle();
    vectors++; if (time_bcd_f !== 12'h999) begin miscompares++; $display("FAIL saturate got %h want 999", time_bcd_f); end
    vectors++; if (time_bcd !== 12'h002) begin miscompares++; $display("FAIL main_isolated got %h want 002", time_bcd); end
  endtask

  task automatic test_dying();
    @(negedge Clk) begin gameover = 1'b1; gamewin = 1'b1; end
    @(negedge Clk) begin gameover = 1'b0; gamewin = 1'b0; end
    vectors++; if (game_state !== 3'd2) begin miscompares++; $display("FAIL dying_priority got %0d want 2", game_state); end
    vectors++; if (play_enable !== 1'b0) begin miscompares++; $display("FAIL dying_play_enable got %b want 0", play_enable); end
    for (int i = 0; i < 89; i++) begin
      confirm = (i == 30);
      frame_pulses(1);
      vectors++; if (game_state !== 3'd2 || play_enable !== 1'b0) begin miscompares++; $display("FAIL dying_hold[%0d] got state %0d pe %b want 2 0", i, game_state, play_enable); end
    end
    confirm = 1'b0;
    settle();
    vectors++; if (game_state !== 3'd2) begin miscompares++; $display("FAIL dying_89 got %0d want 2", game_state); end
    frame_pulses(1);
    settle();
    vectors++; if (game_state !== 3'd3) begin miscompares++; $display("FAIL gameover_90 got %0d want 3", game_state); end
    vectors++; if (play_enable !== 1'b0) begin miscompares++; $display("FAIL gameover_pe got %b want 0", play_enable); end
    vectors++; if (time_bcd !== 12'h002) begin miscompares++; $display("FAIL gameover_time got %h want 002", time_bcd); end
  endtask

  task automatic test_restart();
    @(negedge Clk) confirm = 1'b1;
    @(negedge Clk);
    vectors++; if (game_state !== 3'd1 || revive !== 1'b1) begin miscompares++; $display("FAIL restart got state %0d revive %b want 1 1", game_state, revive); end
    vectors++; if (time_bcd !== 12'h000) begin miscompares++; $display("FAIL restart_time got %h want 000", time_bcd); end
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      vectors++; if (game_state !== 3'd1 || revive !== 1'b0) begin miscompares++; $display("FAIL restart_hold got state %0d revive %b want 1 0", game_state, revive); end
    end
    confirm = 1'b0;
    frame_pulses(58);
    settle();
    vectors++; if (time_bcd !== 12'h000) begin miscompares++; $display("FAIL frame_clear got %h want 000", time_bcd); end
    frame_pulses(2);
    settle();
    vectors++; if (time_bcd !== 12'h001) begin miscompares++; $display("FAIL restart_60 got %h want 001", time_bcd); end
  endtask

  task automatic test_win();
    @(negedge Clk) gamewin = 1'b1;
    @(negedge Clk) gamewin = 1'b0;
    vectors++; if (game_state !== 3'd4 || play_enable !== 1'b0) begin miscompares++; $display("FAIL win got state %0d pe %b want 4 0", game_state, play_enable); end
    frame_pulses(65);
    settle();
    vectors++; if (time_bcd !== 12'h001) begin miscompares++; $display("FAIL win_frozen got %h want 001", time_bcd); end
    @(negedge Clk) confirm = 1'b1;
    @(negedge Clk);
    vectors++; if (game_state !== 3'd0 || revive !== 1'b0) begin miscompares++; $display("FAIL win_to_title got state %0d revive %b want 0 0", game_state, revive); end
    vectors++; if (time_bcd !== 12'h001) begin miscompares++; $display("FAIL title_time got %h want 001", time_bcd); end
    @(negedge Clk) confirm = 1'b0;
    @(negedge Clk) confirm = 1'b1;
    @(negedge Clk);
    vectors++; if (game_state !== 3'd1 || revive !== 1'b1) begin miscompares++; $display("FAIL title_restart got state %0d revive %b want 1 1", game_state, revive); end
    vectors++; if (time_bcd !== 12'h000) begin miscompares++; $display("FAIL title_restart_time got %h want 000", time_bcd); end
    confirm = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge Clk) gameover = 1'b1;
    @(negedge Clk) gameover = 1'b0;
    vectors++; if (game_state !== 3'd2) begin miscompares++; $display("FAIL pre_reset_dying got %0d want 2", game_state); end
    frame_clk = 1'b1;
    repeat (2) @(posedge Clk);
    #5;
    vectors++; if (frame_tick !== 1'b0) begin miscompares++; $display("FAIL tick_latency_2 got %b want 0", frame_tick); end
    @(posedge Clk);
    #5;
    vectors++; if (frame_tick !== 1'b1) begin miscompares++; $display("FAIL tick_latency_3 got %b want 1", frame_tick); end
    Reset_n = 1'b0;
    #1;
    vectors++; if (game_state !== 3'd0 || play_enable !== 1'b0 || revive !== 1'b0) begin miscompares++; $display("FAIL async_reset got state %0d pe %b revive %b want 0 0 0", game_state, play_enable, revive); end
    vectors++; if (frame_tick !== 1'b0 || time_bcd !== 12'h000) begin miscompares++; $display("FAIL async_reset_tick_time got %b %h want 0 000", frame_tick, time_bcd); end
    vectors++; if (time_bcd_f !== 12'h000 || game_state_f !== 3'd0) begin miscompares++; $display("FAIL async_reset_fast got %h %0d want 000 0", time_bcd_f, game_state_f); end
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      vectors++; if (revive !== 1'b0 || game_state !== 3'd0) begin miscompares++; $display("FAIL post_reset got revive %b state %0d want 0 0", revive, game_state); end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    revive_cnt = 0; revive_cnt_f = 0; tick_cnt = 0;
    test_reset();
    test_timer();
    test_saturate();
    test_dying();
    test_restart();
    test_win();
    test_async_reset();
    vectors++; if (revive_cnt !== 3) begin miscompares++; $display("FAIL revive_total got %0d want 3", revive_cnt); end
    vectors++; if (revive_cnt_f !== 1) begin miscompares++; $display("FAIL revive_total_fast got %0d want 1", revive_cnt_f); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/game_flow_fsm.md
Name: game_flow_fsm

Overview:
- Top-level game sequencer sitting directly upstream of the player, score, elevator and water controllers.
- Turns the keyboard `confirm` level and the `gameover`/`gamewin` flags into the game-state machine.
- Produces the one-cycle `revive` pulse that re-initialises downstream controllers, a `play_enable` gate for player motion, and a BCD elapsed-time counter for the HEX display.
- Frame pacing comes from `frame_clk` (~VGA_VS), synchronised into the `Clk` domain.

Parameters:
- FRAMES_PER_SEC, 60: frame ticks per elapsed-time second.
- DEATH_HOLD_FRAMES, 90: frame ticks spent in DYING before GAMEOVER; legal range 1..1023.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset_n  in  1  asynchronous active-low reset.
- frame_clk  in  1  frame strobe (~VGA_VS), asynchronous to Clk.
- confirm  in  1  confirm-key level from keycode mapping; synchronous to Clk.
- gameover  in  1  either player dead; level, synchronous.
- gamewin  in  1  both players at exits; level, synchronous.
- revive  out  1  one-Clk pulse: reset downstream game objects.
- play_enable  out  1  high only in PLAYING.
- game_state  out  3  TITLE=0, PLAYING=1, DYING=2, GAMEOVER=3, WIN=4.
- time_bcd  out  12  elapsed seconds, 3 BCD digits {hundreds, tens, ones}.
- frame_tick  out  1  one-Clk pulse per synchronised frame_clk rising edge.

Behaviour:
- Reset (Reset_n=0, asynchronous): all state cleared at once.
  - Outputs: state=TITLE, revive=0, play_enable=0, time_bcd=12'h000, frame_tick=0.
  - Internal: frame counter=0, hold counter=0, sync flops=0, confirm_prev=1 (a key held through reset is not treated as a press).
- Reset deassertion is taken as-is. No internal reset synchroniser.
- frame_clk path:
  - 2-flop synchroniser, then rising-edge detect against a third flop.
  - frame_tick is registered and asserts 3–4 Clk cycles after the frame_clk rise.
  - Exactly one pulse per rising edge.
- Confirm edge:
  - confirm_rise = confirm & ~confirm_prev; confirm_prev is registered every cycle.
  - A key held across a state change never triggers a second transition; a fresh press is required.
- Transitions (registered; evaluated every Clk cycle):
  - TITLE: confirm_rise -> PLAYING, revive=1 for that one cycle, time_bcd cleared, frame counter cleared.
  - PLAYING:
    - gameover -> DYING, with hold counter loaded to DEATH_HOLD_FRAMES.
    - else gamewin -> WIN.
    - gameover has priority when both are high in the same cycle.
    - confirm is ignored.
  - DYING: hold counter decrements on each frame_tick; on the tick where it reaches 0 -> GAMEOVER. Inputs are ignored.
  - GAMEOVER: confirm_rise -> PLAYING, revive pulse, time_bcd and frame counter cleared.
  - WIN: confirm_rise -> TITLE. No revive pulse; time_bcd holds its value until the next game starts.
- revive:
  - Asserted exactly one cycle, in the same cycle game_state first reads PLAYING.
  - Never asserted in any other case, including during or after Reset_n.
- play_enable = (state==PLAYING), registered alongside state, so it rises together with revive.
- Elapsed timer:
  - Counts only in PLAYING. Frame counter increments per frame_tick; at FRAMES_PER_SEC-1 it wraps to 0 and increments time_bcd.
  - BCD ripple: ones 9->0 carries into tens, tens 9->0 carries into hundreds.
  - Saturates at 12'h999: all digits hold and the frame counter keeps wrapping without further effect.
  - Frozen in DYING, GAMEOVER and WIN.
- Simultaneous events:
  - frame_tick in the cycle PLAYING is exited: the timer increment still applies in that cycle.
  - frame_tick in the cycle revive fires: the clear wins.
- gameover/gamewin asserted while not in PLAYING: no effect.

Test Plan:
- Reset with confirm=1 held, release Reset_n, keep confirm=1 -> state stays TITLE (0) and revive never pulses; drop confirm, then raise it -> next cycle state=1, revive=1 for exactly 1 cycle, play_enable=1.
- In PLAYING, drive 125 frame_clk edges with FRAMES_PER_SEC=60 -> time_bcd=12'h002; force 999 s of ticks -> time_bcd holds at 12'h999.
- In PLAYING, assert gameover and gamewin in the same cycle -> state=2; after 90 frame_ticks -> state=3 with play_enable=0 throughout; time_bcd unchanged from the value at gameover.
- In GAMEOVER, press confirm -> revive single pulse, state=1, time_bcd=12'h000 in the same cycle; holding confirm produces no further transitions.
- In PLAYING, assert gamewin -> state=4, time frozen; press confirm -> state=0, no revive; press confirm again -> state=1 with revive.
- Assert Reset_n low mid-DYING, asynchronously between Clk edges -> all outputs reset immediately; frame_tick=0; no revive pulse after release.
